plane_renderer: RTL
===================

Name: plane_renderer

Overview:
- Consumer end of the plane-controller interface: accepts the ten plane coordinates, visibility mask, op code and the load_coord/enable_datapath/plot strobes.
- Converts them into a serial stream of VGA framebuffer pixel writes, one per clock.
- Draws or erases a fixed-size square sprite for every visible plane, or clears the whole screen.
- Sits between the plane controller and the VGA adapter's x/y/colour/plot write port.

Parameters:
N_PLANES, 10, number of plane slots (bit i of the flat buses is slot i)
SPR_W, 4, sprite width in pixels
SPR_H, 4, sprite height in pixels
X_MAX, 159, last valid screen column
Y_MAX, 119, last valid screen row
DRAW_COLOUR, 3'b111, colour for op=draw
ERASE_COLOUR, 3'b000, colour for op=erase and op=clear

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load_coord  in  1  latch x_flat/y_flat/vis into snapshot registers
enable_datapath  in  1  start-pass strobe (1-cycle pulse or level; acted on only in IDLE)
op  in  2  pass type: 00 none, 01 erase, 10 draw, 11 clear screen
plot  in  1  live write gate; vga_plot = internal write-valid AND plot
x_flat  in  8*N_PLANES  plane i x at [8i+7:8i]
y_flat  in  8*N_PLANES  plane i y at [8i+7:8i]
vis  in  N_PLANES  plane i visible when vis[i]=1
vga_x  out  8  pixel column
vga_y  out  7  pixel row
vga_colour  out  3  pixel colour
vga_plot  out  1  framebuffer write enable
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (sync, any state):
  - FSM goes to IDLE.
  - Snapshot registers and counters clear; all outputs 0.
  - A pass in flight is abandoned with no done pulse.
- Snapshot:
  - load_coord in IDLE latches x_flat, y_flat and vis.
  - load_coord outside IDLE is ignored; the snapshot stays stable for the whole pass.
- Start:
  - enable_datapath in IDLE latches op and leaves IDLE on the next edge.
  - enable_datapath outside IDLE is ignored.
  - load_coord and enable_datapath in the same IDLE cycle: the pass uses the newly loaded values.
- States: IDLE, SEEK, PIXEL, CLEAR, DONE.
- op=00: IDLE -> DONE. busy is high for 1 cycle; done pulses in that cycle.
- op=01/10 (sprite pass), SEEK:
  - A priority encoder picks the lowest-index visible slot not yet drawn from the remaining mask.
  - If found: PIXEL. If none remain: DONE. SEEK always takes exactly 1 cycle.
- PIXEL:
  - Emits SPR_W*SPR_H pixels, 1 per cycle, row-major (dx fastest, 0..SPR_W-1), then dy.
  - Each pixel is vga_x = x+dx, vga_y = y+dy, with the sum computed at 9 bits.
  - After the last pixel the slot's bit is cleared in the remaining mask; return to SEEK.
- Clipping:
  - A pixel with 9-bit x+dx > X_MAX or y+dy > Y_MAX has its write-valid forced to 0.
  - Counters still advance, so cycle count depends only on popcount(vis).
  - vga_x and vga_y carry the truncated low bits of the sum.
- Colour: DRAW_COLOUR for op=10, ERASE_COLOUR for op=01 and op=11.
- op=11 (clear pass):
  - CLEAR walks the raster from (0,0) to (X_MAX,Y_MAX), x fastest, one pixel per cycle, always write-valid.
  - Then DONE.
  - Duration: (X_MAX+1)*(Y_MAX+1) = 19200 cycles.
- Sprite-pass timing, with k = popcount(vis):
  - busy spans k*(1+SPR_W*SPR_H) + 1 SEEK/PIXEL cycles, plus 1 DONE cycle.
  - Default: 17k+2 cycles.
  - First pixel appears 2 cycles after the start edge (start edge -> SEEK -> first PIXEL).
- Output registers:
  - vga_x, vga_y and vga_colour are registered and update in PIXEL/CLEAR cycles.
  - Outside those states they hold 0 and vga_plot is 0.
- plot is sampled combinationally every cycle. Deasserting it suppresses writes but does not stall the pass.
- DONE: done=1 and busy=1 for that cycle, then IDLE (busy=0).
- vis=0 sprite pass: SEEK -> DONE, no writes, busy for 2 cycles.

Test Plan:
- Reset mid-pass:
  - Stimulus: start draw with vis=10'h3FF, assert reset at cycle 40.
  - Response: next cycle all outputs 0, busy=0, no done pulse. A new pass started after reset runs fully.
- Single draw:
  - Stimulus: vis=10'b0000000001, x0=10, y0=20, op=10, plot=1.
  - Response: 16 writes of colour 7 at (10..13, 20..23) row-major; busy for 19 cycles; done asserted once.
- Clip and ordering:
  - Stimulus: vis=10'b0000000101, x0=0, y0=0, x2=158, y2=118, op=01.
  - Response: plane0 gets 16 writes. Plane2 gets writes only at (158..159, 118..119), i.e. 4 writes, colour 0. Total busy = 36 cycles.
- Plot gating and snapshot hold:
  - Stimulus: plot held 0 for cycles 5-9 of a single-plane draw; x_flat changed and load_coord pulsed mid-pass.
  - Response: 5 fewer writes; coordinates unchanged for the remainder of the pass; cycle count unchanged.
- Clear and idle cases:
  - op=11: exactly 19200 writes, colour 0; first (0,0), last (159,119); done after the last write.
  - op=00: done within 1 cycle, no writes.
  - vis=0 with op=10: no writes, busy for 2 cycles.

Source files
------------

// File: rtl/plane_renderer.sv
// Plane renderer: turns the plane-slot snapshot into a serial stream of VGA
// framebuffer writes (sprite draw/erase per visible slot, or full-screen clear).
module plane_renderer #(
  parameter int unsigned N_PLANES     = 10,
  parameter int unsigned SPR_W        = 4,
  parameter int unsigned SPR_H        = 4,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119,
  parameter logic [2:0]  DRAW_COLOUR  = 3'b111,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_coord,
  input  logic                    enable_datapath,
  input  logic [1:0]              op,
  input  logic                    plot,
  input  logic [8*N_PLANES-1:0]   x_flat,
  input  logic [8*N_PLANES-1:0]   y_flat,
  input  logic [N_PLANES-1:0]     vis,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SLOT_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam int unsigned DX_W   = $clog2(SPR_W + 1);
  localparam int unsigned DY_W   = $clog2(SPR_H + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_PIXEL, S_CLEAR, S_DONE} state_t;

  state_t                  state, state_n;
  logic [8*N_PLANES-1:0]   xs, ys;
  logic [N_PLANES-1:0]     vis_s, rem, rem_n;
  logic [1:0]              op_r;
  logic [SLOT_W-1:0]       slot, slot_n, sel;
  logic                    found;
  logic [DX_W-1:0]         dx, dx_n;
  logic [DY_W-1:0]         dy, dy_n;
  logic [7:0]              cx, cx_n;
  logic [6:0]              cy, cy_n;
  logic [8:0]              sx, sy;
  logic [7:0]              x_n;
  logic [6:0]              y_n;
  logic [2:0]              colour_n;
  logic                    valid_n, px_valid;

  // Next-state, counter and next-pixel logic; pixel outputs are computed for
  // the state being entered so they appear registered during that state.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    slot_n   = slot;
    dx_n     = dx;
    dy_n     = dy;
    cx_n     = cx;
    cy_n     = cy;
    sel      = '0;
    found    = 1'b0;
    x_n      = '0;
    y_n      = '0;
    colour_n = '0;
    valid_n  = 1'b0;

    for (int i = int'(N_PLANES) - 1; i >= 0; i--) begin
      if (rem[i]) begin
        found = 1'b1;
        sel   = SLOT_W'(i);
      end
    end

    case (state)
      S_IDLE: begin
        rem_n = load_coord ? vis : vis_s;
        if (enable_datapath) begin
          case (op)
            2'b00:   state_n = S_DONE;
            2'b11: begin
              state_n = S_CLEAR;
              cx_n    = '0;
              cy_n    = '0;
            end
            default: state_n = S_SEEK;
          endcase
        end
      end
      S_SEEK: begin
        if (found) begin
          state_n = S_PIXEL;
          slot_n  = sel;
          dx_n    = '0;
          dy_n    = '0;
        end else begin
          state_n = S_DONE;
        end
      end
      S_PIXEL: begin
        if (dx == DX_W'(SPR_W - 1)) begin
          dx_n = '0;
          if (dy == DY_W'(SPR_H - 1)) begin
            state_n     = S_SEEK;
            rem_n[slot] = 1'b0;
          end else begin
            dy_n = dy + DY_W'(1);
          end
        end else begin
          dx_n = dx + DX_W'(1);
        end
      end
      S_CLEAR: begin
        if (cx == 8'(X_MAX)) begin
          cx_n = '0;
          if (cy == 7'(Y_MAX)) state_n = S_DONE;
          else                 cy_n = cy + 7'd1;
        end else begin
          cx_n = cx + 8'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    sx = {1'b0, xs[{slot_n, 3'b000} +: 8]} + 9'(dx_n);
    sy = {1'b0, ys[{slot_n, 3'b000} +: 8]} + 9'(dy_n);

    case (state_n)
      S_PIXEL: begin
        x_n      = sx[7:0];
        y_n      = sy[6:0];
        colour_n = (op_r == 2'b10) ? DRAW_COLOUR : ERASE_COLOUR;
        valid_n  = (sx <= 9'(X_MAX)) && (sy <= 9'(Y_MAX));
      end
      S_CLEAR: begin
        x_n      = cx_n;
        y_n      = cy_n;
        colour_n = ERASE_COLOUR;
        valid_n  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      xs         <= '0;
      ys         <= '0;
      vis_s      <= '0;
      rem        <= '0;
      op_r       <= '0;
      slot       <= '0;
      dx         <= '0;
      dy         <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      px_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      slot  <= slot_n;
      dx    <= dx_n;
      dy    <= dy_n;
      cx    <= cx_n;
      cy    <= cy_n;
      if (state == S_IDLE && load_coord) begin
        xs    <= x_flat;
        ys    <= y_flat;
        vis_s <= vis;
      end
      if (state == S_IDLE && enable_datapath) op_r <= op;
      vga_x      <= x_n;
      vga_y      <= y_n;
      vga_colour <= colour_n;
      px_valid   <= valid_n;
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

  // Live plot gate: suppresses writes without stalling the pass.
  assign vga_plot = px_valid & plot;

endmodule
